pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Stall/flush/halt sequencer for the 5-stage MIPS pipeline. Sits beside the ID-stage decoder and drives the enables and flushes of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, squashes wrong-path instructions when a branch or jump resolves in MEM, and drains the pipeline on `halt`. It also keeps saturating stall and flush counters for performance measurement.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `DRAIN_CYCLES`, 3: cycles needed to retire instructions older than `halt` (EX, MEM, WB).

One clock; reset is asynchronous and active-low.

- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_instr`  in  32  instruction in IF/ID.
- `id_valid`  in  1  IF/ID holds a real instruction (not a bubble).
- `ex_mem_read`  in  1  MemRead bit of the ID/EX control bundle.
- `ex_dst`  in  5  destination register of the instruction in EX.
- `mem_redirect`  in  1  Branch-taken or jump, resolved in MEM this cycle.
- `pc_en`  out  1  PC register load enable.
- `pc_redirect`  out  1  select branch/jump target for the PC (equals `mem_redirect` in RUN/DRAIN).
- `ifid_en`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  zero the IF/ID register.
- `idex_flush`  out  1  load a bubble (all control 0) into ID/EX.
- `exmem_flush`  out  1  load a bubble into EX/MEM.
- `halted`  out  1  pipeline is fully drained and stopped.
- `stall_cnt`  out  CNT_W  number of load-use stall cycles.
- `flush_cnt`  out  CNT_W  number of redirects.

## Operation
- States: BOOT, RUN, DRAIN, HALTED. Reset enters BOOT. BOOT always goes to RUN on the next clock.
- BOOT: `pc_en`=0, `ifid_en`=0; `ifid_flush`, `idex_flush` and `exmem_flush` are all 1.
- Decode fields: `rs`=`id_instr[25:21]`, `rt`=`id_instr[20:16]`, `op`=`id_instr[31:26]`.
- `uses_rt` is 1 for op 0 (R-type), 4 (beq), 5 (bne) and 43 (sw).
- Load-use hazard is asserted when all of the following hold:
  - `id_valid` and `ex_mem_read` are 1;
  - `ex_dst` is non-zero;
  - `ex_dst` matches `rs`, or `uses_rt` is 1 and `ex_dst` matches `rt`.
- Priority in RUN, highest first:
  - Redirect: `mem_redirect`=1. Drive `pc_en`=1, `pc_redirect`=1, and flush IF/ID, ID/EX and EX/MEM. Increment `flush_cnt`. Stay in RUN.
  - Load-use: `pc_en`=0, `ifid_en`=0, `idex_flush`=1. Increment `stall_cnt`. Stay in RUN. The hazard clears on the next cycle because the load moves to MEM.
  - Halt: `id_valid` and `op`=6'b111111. Apply `pc_en`=0, `ifid_en`=0, `idex_flush`=1. Load drain counter with DRAIN_CYCLES-1 and go to DRAIN.
  - Otherwise: `pc_en`=1, `ifid_en`=1, all flushes 0.
- DRAIN:
  - Outputs are the same as the halt case.
  - If `mem_redirect`=1, an older branch has cancelled the halt. Perform the redirect action, increment `flush_cnt`, and return to RUN.
  - Otherwise decrement the counter. At 0, go to HALTED.
- HALTED: `halted`=1, `pc_en`=0, `ifid_en`=0, `idex_flush`=1. The block leaves HALTED only on reset.
- Counters saturate at all-ones. They are not cleared by halt.

## Timing
- Reset values:
  - state BOOT, drain counter 0, `stall_cnt`=0, `flush_cnt`=0, `halted`=0.
  - `pc_en`=0, `ifid_en`=0, `pc_redirect`=0.
  - `ifid_flush`=1, `idex_flush`=1, `exmem_flush`=1.
- Reset asserted mid-DRAIN or in HALTED returns the block to BOOT immediately (asynchronous).
- All control outputs are combinational from the registered state and the current inputs. There is zero-cycle latency from a hazard or redirect to the enables.
- Counters and the drain counter update on the `clk` rising edge.
- `halted` is registered and rises DRAIN_CYCLES cycles after `halt` is seen in ID.
- Simultaneous events:
  - Redirect plus load-use: redirect wins and the stall is not counted.
  - Redirect plus halt in ID: redirect wins and the halt is squashed.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants `OP_RTYPE`, `OP_BEQ`, `OP_BNE`, `OP_SW`, `OP_LW`, `OP_HALT`;
  - the state enum `pctl_state_t`.
- The decoder already uses the same opcode constants, so they live in the package rather than in this block.
- Sub-module `load_use_detect` is purely combinational: field extraction, `uses_rt` and the register compare. The top level holds the FSM, the drain counter and the performance counters.

## Test plan
- **Boot:** release `rst_n` → one BOOT cycle with all flushes 1, then RUN with `pc_en`=1.
- **Load-use stall:** `lw $2` in EX (`ex_mem_read`=1, `ex_dst`=2), `add $3,$2,$4` in ID → one cycle of `pc_en`=0, `idex_flush`=1, then `stall_cnt`=1.
- **No-hazard case:** same setup with `ex_dst`=0 → no stall. `ori` (`uses_rt`=0) with `rt`=2 → no stall.
- **Redirect beats stall:** `mem_redirect`=1 in the same cycle as a load-use → `pc_redirect`=1, all three flushes 1, `flush_cnt`=1, `stall_cnt` unchanged.
- **Halt drain:** `halt` in ID → DRAIN for 3 cycles, `halted`=1 on the 4th edge, `pc_en` held at 0 afterwards.
- **Halt cancel and reset:** `mem_redirect` in the 2nd DRAIN cycle → back to RUN with `halted`=0. Separately, pulse `rst_n` low while HALTED → BOOT with counters 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants and pipeline-control state shared by the decoder and pipeline_ctrl
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_HALT  = 6'd63;
    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} pctl_state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage instruction that reads the register a load in EX is still fetching
module load_use_detect
    import mips_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dst,
    output logic        hazard
);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       uses_rt;
    assign op      = id_instr[31:26];
    assign rs      = id_instr[25:21];
    assign rt      = id_instr[20:16];
    assign uses_rt = op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
    assign hazard  = id_valid && ex_mem_read && ex_dst != 5'd0 &&
                     (ex_dst == rs || (uses_rt && ex_dst == rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt sequencer driving PC and pipeline-register enables, with perf counters
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dst,
    input  logic             mem_redirect,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    pctl_state_t state, nstate;
    logic [DW-1:0] drain_q;
    logic hazard, halt_id;
    logic stall_inc, flush_inc, drain_load, drain_dec;
    load_use_detect u_lud (
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .ex_mem_read(ex_mem_read),
        .ex_dst     (ex_dst),
        .hazard     (hazard)
    );
    assign halt_id = id_valid && id_instr[31:26] == OP_HALT;
    always_comb begin
        nstate      = state;
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        drain_load  = 1'b0;
        drain_dec   = 1'b0;
        case (state)
            BOOT: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                nstate      = RUN;
            end
            RUN: begin
                if (mem_redirect) begin
                    pc_en       = 1'b1;
                    pc_redirect = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (hazard) begin
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (halt_id) begin
                    idex_flush = 1'b1;
                    drain_load = 1'b1;
                    nstate     = DRAIN;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            DRAIN: begin
                idex_flush = 1'b1;
                // an older branch resolving in MEM cancels the halt
                if (mem_redirect) begin
                    pc_en       = 1'b1;
                    pc_redirect = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                    nstate      = RUN;
                end else if (drain_q == '0) begin
                    nstate = HALTED;
                end else begin
                    drain_dec = 1'b1;
                end
            end
            default: idex_flush = 1'b1;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            drain_q   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            state  <= nstate;
            halted <= nstate == HALTED;
            if (drain_load)
                drain_q <= DW'(DRAIN_CYCLES - 1);
            else if (drain_dec)
                drain_q <= drain_q - DW'(1);
            if (stall_inc && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed test-plan steps then randomized traffic, checked against a cycle-level behavioural model
module tb_pipeline_ctrl;
    localparam int CNT_W = 6;
    localparam int DRAIN = 3;
    localparam int SAT   = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] id_instr;
    logic id_valid, ex_mem_read, mem_redirect;
    logic [4:0] ex_dst;
    logic pc_en, pc_redirect, ifid_en, ifid_flush, idex_flush, exmem_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int total = 0;
    int pass  = 0;
    bit m_boot, m_halted;
    int m_drain, m_stall, m_flush;
    always #5 clk = ~clk;
    pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .mem_redirect(mem_redirect),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    function automatic logic [31:0] mk(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0};
    endfunction
    function automatic bit m_hazard();
        int op = int'(id_instr[31:26]);
        int rs = int'(id_instr[25:21]);
        int rt = int'(id_instr[20:16]);
        int d  = int'(ex_dst);
        bit reads_rt = op == 0 || op == 4 || op == 5 || op == 43;
        return id_valid && ex_mem_read && d != 0 && (d == rs || (reads_rt && d == rt));
    endfunction
    function automatic bit m_halt_seen();
        return id_valid && id_instr[31:26] == 6'd63;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask
    task automatic check_outs();
        bit e_pc = 0, e_red = 0, e_ifen = 0, e_iff = 0, e_idf = 0, e_exf = 0, skip_ifen = 0;
        if (m_boot) begin
            e_iff = 1; e_idf = 1; e_exf = 1;
        end else if (m_halted) begin
            e_idf = 1;
        end else if (mem_redirect) begin
            e_pc = 1; e_red = 1; e_iff = 1; e_idf = 1; e_exf = 1; skip_ifen = 1;
        end else if (m_drain > 0 || m_hazard() || m_halt_seen()) begin
            e_idf = 1;
        end else begin
            e_pc = 1; e_ifen = 1;
        end
        chk("pc_en", 32'(pc_en), 32'(e_pc));
        chk("pc_redirect", 32'(pc_redirect), 32'(e_red));
        if (!skip_ifen) chk("ifid_en", 32'(ifid_en), 32'(e_ifen));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        chk("idex_flush", 32'(idex_flush), 32'(e_idf));
        chk("exmem_flush", 32'(exmem_flush), 32'(e_exf));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask
    task automatic advance();
        if (m_boot) m_boot = 0;
        else if (m_halted) begin end
        else if (mem_redirect) begin
            m_flush = m_flush < SAT ? m_flush + 1 : SAT;
            m_drain = 0;
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_halted = 1;
        end else if (m_hazard()) m_stall = m_stall < SAT ? m_stall + 1 : SAT;
        else if (m_halt_seen()) m_drain = DRAIN;
    endtask
    task automatic model_reset();
        m_boot = 1; m_halted = 0; m_drain = 0; m_stall = 0; m_flush = 0;
    endtask
    task automatic step(input logic [31:0] ins, input bit v, input bit mr, input int dst, input bit redir);
        id_instr = ins; id_valid = v; ex_mem_read = mr; ex_dst = 5'(dst); mem_redirect = redir;
        @(negedge clk);
        check_outs();
        @(posedge clk);
        advance();
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        #1 rst_n = 1'b1;
    endtask
    initial begin
        rst_n = 1'b0; id_instr = '0; id_valid = 0; ex_mem_read = 0; ex_dst = '0; mem_redirect = 0;
        model_reset();
        #2 check_outs();
        #5 rst_n = 1'b1;
        step(mk(0, 0, 0), 0, 0, 0, 0);
        step(mk(0, 1, 1), 1, 0, 0, 0);
        step(mk(0, 2, 4), 1, 1, 2, 0);
        step(mk(0, 2, 4), 1, 0, 2, 0);
        step(mk(0, 0, 4), 1, 1, 0, 0);
        step(mk(13, 5, 2), 1, 1, 2, 0);
        step(mk(43, 7, 2), 1, 1, 2, 0);
        step(mk(0, 2, 4), 0, 1, 2, 0);
        step(mk(0, 2, 4), 1, 1, 2, 1);
        step(mk(0, 3, 3), 1, 0, 0, 0);
        step(mk(63, 0, 0), 1, 0, 0, 0);
        repeat (DRAIN) step(mk(0, 1, 1), 0, 0, 0, 0);
        repeat (3) step(mk(0, 1, 1), 1, 0, 0, 0);
        do_reset();
        step(mk(0, 0, 0), 0, 0, 0, 0);
        step(mk(63, 0, 0), 1, 0, 0, 0);
        step(mk(0, 0, 0), 0, 0, 0, 0);
        step(mk(0, 0, 0), 0, 0, 0, 1);
        step(mk(0, 1, 1), 1, 0, 0, 0);
        step(mk(63, 0, 0), 1, 0, 0, 1);
        step(mk(0, 1, 1), 1, 0, 0, 0);
        step(mk(63, 0, 0), 1, 0, 0, 0);
        step(mk(0, 0, 0), 0, 0, 0, 0);
        do_reset();
        repeat (SAT + 5) step(mk(0, 0, 0), 0, 0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            int ops[7] = '{0, 4, 5, 43, 35, 13, 8};
            int op = $urandom_range(15) == 0 ? 63 : ops[$urandom_range(6)];
            if ((m_halted && $urandom_range(3) == 0) || $urandom_range(99) == 0) do_reset();
            step(mk(op, $urandom_range(3), $urandom_range(3)), $urandom_range(4) != 0,
                 $urandom_range(1) == 1, $urandom_range(3), $urandom_range(5) == 0);
        end
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
